// File: rtl/sent_tx_pkg.sv
// Shared types, constants and the CRC4 step function for the SENT transmitter.
// The CRC step is computed from the XOR-of-constants form of the lookup table.
package sent_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        STATUS,
        DATA,
        CRC,
        PAUSE
    } tx_state_e;

    localparam logic [3:0] CRC_SEED          = 4'h5;
    localparam int         NIBBLE_BASE_TICKS = 12;
    localparam int         MIN_PAUSE_TICKS   = 12;
    localparam int         NUM_DATA_NIBBLES  = 6;

    // One table step followed by the nibble fold-in: T[crc] ^ nibble.
    function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic [3:0] nibble);
        logic [3:0] t;
        t = 4'h0;
        if (crc[0]) t = t ^ 4'hD;
        if (crc[1]) t = t ^ 4'h7;
        if (crc[2]) t = t ^ 4'hE;
        if (crc[3]) t = t ^ 4'h1;
        return t ^ nibble;
    endfunction

endpackage

// File: rtl/sent_tx_tick_gen.sv
// SENT tick divider: strobes tick on the wrap cycle of a 0..TICK_DIV-1 counter.
// restart forces the count back to 0 so a new frame starts on a clean tick boundary.
module sent_tx_tick_gen #(
    parameter int TICK_DIV = 3
) (
    input  logic clk_tx,
    input  logic reset_tx,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// SENT transmitter: turns one accepted frame into sync, status, six data, CRC
// and optional pause pulses on data_pulse, with back-to-back frame chaining.
module sent_tx_pulse_gen
    import sent_tx_pkg::*;
#(
    parameter int TICK_DIV   = 3,
    parameter int LOW_TICKS  = 5,
    parameter int SYNC_TICKS = 56
) (
    input  logic        clk_tx,
    input  logic        reset_tx,
    input  logic        frame_valid,
    output logic        frame_ready,
    input  logic [3:0]  status_nibble,
    input  logic [23:0] data_nibbles,
    input  logic [9:0]  pause_ticks,
    output logic        data_pulse,
    output logic        busy,
    output logic        frame_done,
    output logic [3:0]  crc_sent
);

    tx_state_e   state_q, state_d;
    logic [9:0]  period_cnt_q, period_cnt_d;
    logic [2:0]  nib_idx_q, nib_idx_d;
    logic [3:0]  status_q, status_d;
    logic [23:0] data_q, data_d;
    logic [9:0]  pause_q, pause_d;
    logic [3:0]  crc_acc_q, crc_acc_d;
    logic [3:0]  crc_sent_q, crc_sent_d;
    logic        data_pulse_q, data_pulse_d;

    logic        tick;
    logic        accept;
    logic        period_end;
    logic        final_period;
    logic        last_clk;
    logic [9:0]  period_len;
    logic [9:0]  pause_clamped;
    logic [3:0]  data_nib [NUM_DATA_NIBBLES];

    sent_tx_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk_tx   (clk_tx),
        .reset_tx (reset_tx),
        .restart  (accept),
        .tick     (tick)
    );

    // Nibble 1 sits in the top bits and is transmitted first.
    for (genvar gi = 0; gi < NUM_DATA_NIBBLES; gi++) begin : g_nib
        assign data_nib[gi] = data_q[(NUM_DATA_NIBBLES - 1 - gi) * 4 +: 4];
    end

    always_comb begin
        period_len = 10'd0;
        case (state_q)
            SYNC:    period_len = 10'(SYNC_TICKS);
            STATUS:  period_len = 10'(NIBBLE_BASE_TICKS) + {6'd0, status_q};
            DATA:    period_len = 10'(NIBBLE_BASE_TICKS) + {6'd0, data_nib[nib_idx_q]};
            CRC:     period_len = 10'(NIBBLE_BASE_TICKS) + {6'd0, crc_sent_q};
            PAUSE:   period_len = pause_q;
            default: period_len = 10'd0;
        endcase
    end

    always_comb begin
        pause_clamped = pause_ticks;
        if ((pause_ticks != 10'd0) && (pause_ticks < 10'(MIN_PAUSE_TICKS))) begin
            pause_clamped = 10'(MIN_PAUSE_TICKS);
        end
    end

    assign period_end   = tick && (state_q != IDLE) && (period_cnt_q == period_len - 10'd1);
    assign final_period = (state_q == PAUSE) || ((state_q == CRC) && (pause_q == 10'd0));
    assign last_clk     = period_end && final_period;
    assign frame_ready  = (state_q == IDLE) || last_clk;
    assign accept       = frame_valid && frame_ready;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        nib_idx_d    = nib_idx_q;
        status_d     = status_q;
        data_d       = data_q;
        pause_d      = pause_q;
        crc_acc_d    = crc_acc_q;
        crc_sent_d   = crc_sent_q;

        if (tick && (state_q != IDLE)) begin
            period_cnt_d = period_cnt_q + 10'd1;
        end

        if (period_end) begin
            period_cnt_d = 10'd0;
            case (state_q)
                SYNC: state_d = STATUS;
                STATUS: begin
                    state_d   = DATA;
                    nib_idx_d = 3'd0;
                    crc_acc_d = crc4_step(crc_acc_q, data_nib[0]);
                end
                DATA: begin
                    if (nib_idx_q == 3'(NUM_DATA_NIBBLES - 1)) begin
                        // Augmentation step: one more table pass with a zero nibble.
                        state_d    = CRC;
                        crc_sent_d = crc4_step(crc_acc_q, 4'h0);
                    end else begin
                        nib_idx_d = nib_idx_q + 3'd1;
                        crc_acc_d = crc4_step(crc_acc_q, data_nib[nib_idx_q + 3'd1]);
                    end
                end
                CRC:     state_d = (pause_q != 10'd0) ? PAUSE : IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (accept) begin
            state_d      = SYNC;
            period_cnt_d = 10'd0;
            nib_idx_d    = 3'd0;
            status_d     = status_nibble;
            data_d       = data_nibbles;
            pause_d      = pause_clamped;
            crc_acc_d    = CRC_SEED;
        end

        // Registered from next-state values so the line edge lines up with the state change.
        data_pulse_d = (state_d == IDLE) || (period_cnt_d >= 10'(LOW_TICKS));
    end

    always_ff @(posedge clk_tx) begin
        if (reset_tx) begin
            state_q      <= IDLE;
            period_cnt_q <= 10'd0;
            nib_idx_q    <= 3'd0;
            status_q     <= 4'h0;
            data_q       <= 24'h0;
            pause_q      <= 10'd0;
            crc_acc_q    <= 4'h0;
            crc_sent_q   <= 4'h0;
            data_pulse_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            nib_idx_q    <= nib_idx_d;
            status_q     <= status_d;
            data_q       <= data_d;
            pause_q      <= pause_d;
            crc_acc_q    <= crc_acc_d;
            crc_sent_q   <= crc_sent_d;
            data_pulse_q <= data_pulse_d;
        end
    end

    assign data_pulse = data_pulse_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = last_clk;
    assign crc_sent   = crc_sent_q;

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Directed bench for sent_tx_pulse_gen: measures every period and low phase from
// line edges and compares against hand-computed frame timing and CRC values.
module tb_sent_tx_pulse_gen;

    localparam int DIV  = 3;
    localparam int LOW  = 5;
    localparam int SYNC = 56;

    logic        clk_tx        = 1'b0;
    logic        reset_tx      = 1'b1;
    logic        frame_valid   = 1'b0;
    logic [3:0]  status_nibble = 4'h0;
    logic [23:0] data_nibbles  = 24'h0;
    logic [9:0]  pause_ticks   = 10'd0;
    logic        frame_ready;
    logic        data_pulse;
    logic        busy;
    logic        frame_done;
    logic [3:0]  crc_sent;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor-owned state, written only by the negedge monitor below.
    int   cyc        = 0;
    int   done_cnt   = 0;
    int   last_done  = 0;
    int   busy_low   = 0;
    int   ready_busy = 0;
    int   fall_q[$];
    int   rise_q[$];
    logic prev_pulse = 1'b1;

    // Hand-computed vectors: status, data, pause, expected CRC.
    logic [3:0]  v_st  [4];
    logic [23:0] v_dat [4];
    logic [9:0]  v_pau [4];
    logic [3:0]  v_crc [4];

    sent_tx_pulse_gen #(
        .TICK_DIV   (DIV),
        .LOW_TICKS  (LOW),
        .SYNC_TICKS (SYNC)
    ) dut (
        .clk_tx        (clk_tx),
        .reset_tx      (reset_tx),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .status_nibble (status_nibble),
        .data_nibbles  (data_nibbles),
        .pause_ticks   (pause_ticks),
        .data_pulse    (data_pulse),
        .busy          (busy),
        .frame_done    (frame_done),
        .crc_sent      (crc_sent)
    );

    always #5 clk_tx = ~clk_tx;

    always @(posedge clk_tx) cyc++;

    always @(negedge clk_tx) begin
        if (prev_pulse && !data_pulse) fall_q.push_back(cyc);
        if (!prev_pulse && data_pulse) rise_q.push_back(cyc);
        prev_pulse = data_pulse;
        if (frame_done === 1'b1) begin
            done_cnt++;
            last_done = cyc;
        end
        if (busy !== 1'b1) busy_low++;
        if (busy === 1'b1 && frame_ready === 1'b1) ready_busy++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_pause(input logic [9:0] p);
        if (p == 10'd0) return 0;
        if (p < 10'd12) return 12;
        return int'(p);
    endfunction

    function automatic int n_periods(input int v);
        return (v_pau[v] != 10'd0) ? 10 : 9;
    endfunction

    function automatic int exp_period(input int v, input int i);
        logic [23:0] d;
        if (i == 0) return SYNC * DIV;
        if (i == 1) return (12 + int'(v_st[v])) * DIV;
        if (i <= 7) begin
            d = v_dat[v] >> (4 * (7 - i));
            return (12 + int'(d[3:0])) * DIV;
        end
        if (i == 8) return (12 + int'(v_crc[v])) * DIV;
        return exp_pause(v_pau[v]) * DIV;
    endfunction

    task automatic drive(input int v);
        status_nibble = v_st[v];
        data_nibbles  = v_dat[v];
        pause_ticks   = v_pau[v];
    endtask

    task automatic wait_done(input int prev, output int dc);
        for (int k = 0; k < 6000 && done_cnt == prev; k++) @(posedge clk_tx);
        #1;
        check("done_seen", int'(done_cnt != prev), 1);
        dc = last_done;
    endtask

    task automatic check_frame(input int v, input int fb, input int rb, input int acc, input int dc);
        int n;
        int got;
        n = n_periods(v);
        check($sformatf("v%0d_fall_count", v), fall_q.size() - fb, n);
        if (fall_q.size() >= fb + n && rise_q.size() >= rb + n) begin
            check($sformatf("v%0d_sync_latency", v), fall_q[fb] - acc, 1);
            for (int i = 0; i < n; i++) begin
                if (i < n - 1) got = fall_q[fb + i + 1] - fall_q[fb + i];
                else           got = dc - fall_q[fb + i] + 1;
                check($sformatf("v%0d_period%0d", v, i), got, exp_period(v, i));
                check($sformatf("v%0d_low%0d", v, i), rise_q[rb + i] - fall_q[fb + i], LOW * DIV);
            end
        end
        check($sformatf("v%0d_crc_sent", v), int'(crc_sent), int'(v_crc[v]));
    endtask

    task automatic run_frame(input int v);
        int fb, rb, acc, dn, rbz, dc;
        fb  = fall_q.size();
        rb  = rise_q.size();
        dn  = done_cnt;
        rbz = ready_busy;
        @(posedge clk_tx); #1;
        drive(v);
        frame_valid = 1'b1;
        acc = cyc;
        @(posedge clk_tx); #1;
        frame_valid = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("ready_mid_frame", int'(frame_ready), 0);
        wait_done(dn, dc);
        check_frame(v, fb, rb, acc, dc);
        check("done_count", done_cnt - dn, 1);
        check("ready_while_busy", ready_busy - rbz, 1);
        check("idle_busy", int'(busy), 0);
        check("idle_ready", int'(frame_ready), 1);
        check("idle_line", int'(data_pulse), 1);
        $display("frame v%0d: status=%h data=%h pause=%0d crc_sent=%h done@%0d",
                 v, v_st[v], v_dat[v], v_pau[v], crc_sent, dc);
    endtask

    task automatic run_back_to_back();
        int fb, rb, acc, dn, rbz, blz, d1, d2;
        fb  = fall_q.size();
        rb  = rise_q.size();
        dn  = done_cnt;
        rbz = ready_busy;
        @(posedge clk_tx); #1;
        drive(2);
        frame_valid = 1'b1;
        acc = cyc;
        @(posedge clk_tx); #1;
        drive(0);
        blz = busy_low;
        wait_done(dn, d1);
        frame_valid = 1'b0;
        check_frame(2, fb, rb, acc, d1);
        wait_done(dn + 1, d2);
        check_frame(0, fb + 10, rb + 10, d1, d2);
        check("b2b_busy_gap", busy_low - blz, 0);
        check("b2b_done_count", done_cnt - dn, 2);
        check("b2b_ready_while_busy", ready_busy - rbz, 2);
        $display("back-to-back: first done@%0d second done@%0d", d1, d2);
    endtask

    task automatic run_reset_abort();
        int fb, dn;
        fb = fall_q.size();
        @(posedge clk_tx); #1;
        drive(3);
        frame_valid = 1'b1;
        @(posedge clk_tx); #1;
        frame_valid = 1'b0;
        for (int k = 0; k < 3000 && fall_q.size() < fb + 6; k++) @(posedge clk_tx);
        #1;
        check("abort_reach_data", int'(fall_q.size() >= fb + 6), 1);
        repeat (5) @(posedge clk_tx);
        #1;
        check("abort_line_low", int'(data_pulse), 0);
        dn = done_cnt;
        reset_tx = 1'b1;
        @(posedge clk_tx); #1;
        reset_tx = 1'b0;
        check("abort_line", int'(data_pulse), 1);
        check("abort_busy", int'(busy), 0);
        check("abort_ready", int'(frame_ready), 1);
        check("abort_crc", int'(crc_sent), 0);
        fb = fall_q.size();
        repeat (300) @(posedge clk_tx);
        #1;
        check("abort_no_done", done_cnt - dn, 0);
        check("abort_no_falls", fall_q.size() - fb, 0);
        $display("reset abort: line=%0b busy=%0b ready=%0b", data_pulse, busy, frame_ready);
    endtask

    initial begin
        v_st[0] = 4'h0; v_dat[0] = 24'h000000; v_pau[0] = 10'd0;   v_crc[0] = 4'h5;
        v_st[1] = 4'hF; v_dat[1] = 24'hFFFFFF; v_pau[1] = 10'd0;   v_crc[1] = 4'hA;
        v_st[2] = 4'h3; v_dat[2] = 24'h123456; v_pau[2] = 10'd5;   v_crc[2] = 4'h2;
        v_st[3] = 4'hA; v_dat[3] = 24'hABCDEF; v_pau[3] = 10'd300; v_crc[3] = 4'h7;

        reset_tx = 1'b1;
        repeat (3) @(posedge clk_tx);
        #1;
        check("rst_line", int'(data_pulse), 1);
        check("rst_ready", int'(frame_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_crc", int'(crc_sent), 0);
        reset_tx = 1'b0;
        @(posedge clk_tx); #1;
        check("post_rst_line", int'(data_pulse), 1);
        check("post_rst_busy", int'(busy), 0);
        $display("reset: line=%0b ready=%0b busy=%0b crc=%h", data_pulse, frame_ready, busy, crc_sent);

        for (int v = 0; v < 4; v++) run_frame(v);
        run_back_to_back();
        run_reset_abort();
        run_frame(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
